// File: rtl/uart_tx_scheduler_pkg.sv
// UART 16550 register map and scheduler state encoding for uart_tx_scheduler.
// The INIT_* states exist only when UART_SCHED_INIT_EN is defined.
package uart_package;

    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER     = 3'd1;
    localparam logic [2:0] FCR     = 3'd2;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] LSR     = 3'd5;
    localparam logic [2:0] DLL     = 3'd0;
    localparam logic [2:0] DLM     = 3'd1;

    localparam int LSR_THRE_BIT = 5;

`ifdef UART_SCHED_INIT_EN
    typedef enum logic [2:0] {
        INIT_LCR_DLAB = 3'd0,
        INIT_DLL      = 3'd1,
        INIT_DLM      = 3'd2,
        INIT_LCR      = 3'd3,
        INIT_FCR      = 3'd4,
        IDLE          = 3'd5,
        POLL_LSR      = 3'd6,
        WRITE_THR     = 3'd7
    } sched_state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd5,
        POLL_LSR  = 3'd6,
        WRITE_THR = 3'd7
    } sched_state_t;
`endif

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin grant: lowest-index valid requester at or after
// rr_ptr, wrapping modulo NREQ.
module uart_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] grant,
    output logic             grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        // Walk offsets from farthest to nearest so the nearest valid one wins.
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (valid[PTR_W'(idx)]) begin
                grant       = PTR_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Feeds bytes from NREQ requesters into a 16550-style UART over Wishbone,
// pacing THR writes by bursts gated on LSR.THRE. Define UART_SCHED_INIT_EN
// to run the UART register init sequence after reset.
//
// state         | meaning
// --------------+---------------------------------------------------
// INIT_LCR_DLAB | write LCR with DLAB set (init build only)
// INIT_DLL      | write divisor low byte (init build only)
// INIT_DLM      | write divisor high byte (init build only)
// INIT_LCR      | write LCR with DLAB clear (init build only)
// INIT_FCR      | enable and clear FIFOs (init build only)
// IDLE          | wait for any requester
// POLL_LSR      | read LSR until THRE is set
// WRITE_THR     | write granted byte to THR, up to BURST per THRE
module uart_tx_scheduler #(
    parameter int          NREQ    = 4,
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter int          BURST   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [2:0]        wb_adr_o,
    output logic [7:0]        wb_dat_o,
    input  logic [7:0]        wb_dat_i,
    input  logic              wb_ack_i,
    output logic              init_done_o,
    output logic              busy_o
);

    import uart_package::*;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(BURST + 1);

`ifdef UART_SCHED_INIT_EN
    localparam sched_state_t RESET_STATE = INIT_LCR_DLAB;
`else
    localparam sched_state_t RESET_STATE = IDLE;
`endif

    sched_state_t     state, state_nxt;
    logic             cyc_q, cyc_nxt;
    logic             we_q, we_nxt;
    logic [2:0]       adr_q, adr_nxt;
    logic [7:0]       dat_q, dat_nxt;
    logic [PTR_W-1:0] grant_q, grant_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt, cnt_dec;
    logic [PTR_W-1:0] arb_grant;
    logic             arb_valid;
    logic [7:0]       arb_byte;
    logic             ack_ev;
    logic             start;
    logic             thre;
    logic [NREQ-1:0]  valid_rem;
    logic             unused_rd;

    assign ack_ev    = cyc_q & wb_ack_i & ~rst_i;
    assign start     = ~cyc_q;
    assign thre      = wb_dat_i[LSR_THRE_BIT];
    assign cnt_dec   = burst_cnt - CNT_W'(1);
    // The byte being accepted this cycle no longer counts as pending.
    assign valid_rem = req_valid_i & ~req_ready_o;
    assign unused_rd = ^{wb_dat_i[7:LSR_THRE_BIT+1], wb_dat_i[LSR_THRE_BIT-1:0]};

    uart_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .valid       (req_valid_i),
        .rr_ptr      (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        arb_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant == PTR_W'(i)) begin
                arb_byte = req_data_i[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RESET_STATE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            grant_q   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cyc_q   <= cyc_nxt;
            we_q    <= we_nxt;
            adr_q   <= adr_nxt;
            dat_q   <= dat_nxt;
            grant_q <= grant_nxt;
            if (state == POLL_LSR && ack_ev && thre) begin
                burst_cnt <= CNT_W'(BURST);
            end else if (state == WRITE_THR && ack_ev) begin
                burst_cnt <= (|valid_rem) ? cnt_dec : '0;
                rr_ptr    <= (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + PTR_W'(1);
            end else if (state == WRITE_THR && start && !arb_valid) begin
                burst_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef UART_SCHED_INIT_EN
            INIT_LCR_DLAB: if (ack_ev) state_nxt = INIT_DLL;
            INIT_DLL:      if (ack_ev) state_nxt = INIT_DLM;
            INIT_DLM:      if (ack_ev) state_nxt = INIT_LCR;
            INIT_LCR:      if (ack_ev) state_nxt = INIT_FCR;
            INIT_FCR:      if (ack_ev) state_nxt = IDLE;
`endif
            IDLE: begin
                if (|req_valid_i) state_nxt = POLL_LSR;
            end
            POLL_LSR: begin
                if (ack_ev && thre) state_nxt = WRITE_THR;
            end
            WRITE_THR: begin
                if (start && !arb_valid) begin
                    state_nxt = IDLE;
                end else if (ack_ev) begin
                    if (cnt_dec == '0) begin
                        state_nxt = (|valid_rem) ? POLL_LSR : IDLE;
                    end else if (!(|valid_rem)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = RESET_STATE;
        endcase
    end

    always_comb begin
        cyc_nxt     = cyc_q;
        we_nxt      = we_q;
        adr_nxt     = adr_q;
        dat_nxt     = dat_q;
        grant_nxt   = grant_q;
        req_ready_o = '0;
        if (cyc_q) begin
            if (ack_ev) begin
                cyc_nxt = 1'b0;
                we_nxt  = 1'b0;
                adr_nxt = '0;
                dat_nxt = '0;
            end
        end else begin
            case (state)
`ifdef UART_SCHED_INIT_EN
                INIT_LCR_DLAB: begin
                    cyc_nxt = 1'b1; we_nxt = 1'b1; adr_nxt = LCR; dat_nxt = LCR_VAL | 8'h80;
                end
                INIT_DLL: begin
                    cyc_nxt = 1'b1; we_nxt = 1'b1; adr_nxt = DLL; dat_nxt = DIVISOR[7:0];
                end
                INIT_DLM: begin
                    cyc_nxt = 1'b1; we_nxt = 1'b1; adr_nxt = DLM; dat_nxt = DIVISOR[15:8];
                end
                INIT_LCR: begin
                    cyc_nxt = 1'b1; we_nxt = 1'b1; adr_nxt = LCR; dat_nxt = LCR_VAL & 8'h7F;
                end
                INIT_FCR: begin
                    cyc_nxt = 1'b1; we_nxt = 1'b1; adr_nxt = FCR; dat_nxt = 8'h07;
                end
`endif
                POLL_LSR: begin
                    cyc_nxt = 1'b1; we_nxt = 1'b0; adr_nxt = LSR; dat_nxt = '0;
                end
                WRITE_THR: begin
                    if (arb_valid) begin
                        cyc_nxt   = 1'b1;
                        we_nxt    = 1'b1;
                        adr_nxt   = RBR_THR;
                        dat_nxt   = arb_byte;
                        grant_nxt = arb_grant;
                    end
                end
                default: ;
            endcase
        end
        if (state == WRITE_THR && ack_ev) begin
            req_ready_o = NREQ'(1) << grant_q;
        end
    end

`ifdef UART_SCHED_INIT_EN
    logic init_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_done_q <= 1'b0;
        end else if (state == INIT_FCR && ack_ev) begin
            init_done_q <= 1'b1;
        end
    end

    assign init_done_o = init_done_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{DIVISOR, LCR_VAL};
    assign init_done_o = 1'b1;
`endif

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign busy_o   = cyc_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a Wishbone slave model serves each
// access and pops the expected access from a scoreboard queue.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst_i;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*8-1:0] req_data_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [2:0]        wb_adr_o;
    logic [7:0]        wb_dat_o;
    logic [7:0]        wb_dat_i;
    logic              wb_ack_i;
    logic              init_done_o;
    logic              busy_o;

    typedef struct {
        logic [2:0] adr;
        logic       we;
        logic [7:0] dat;
        logic [3:0] rdy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq_cnt [NREQ];

    uart_tx_scheduler #(
        .NREQ    (NREQ),
        .DIVISOR (16'd27),
        .LCR_VAL (8'h03),
        .BURST   (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .init_done_o (init_done_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] adr, input logic we, input logic [7:0] dat,
                        input logic [3:0] rdy);
        exp_t e;
        e.adr = adr; e.we = we; e.dat = dat; e.rdy = rdy;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] req_byte(input int g);
        return {4'(g), 4'(seq_cnt[g])};
    endfunction

    task automatic set_byte(input int g, input logic [7:0] v);
        req_data_i[g*8 +: 8] = v;
    endtask

    // Waits (bounded) for a cycle, checks it against the scoreboard, holds it
    // for dly cycles, acks with rd and checks the ready pulse and release.
    task automatic serve(input string tag, input int dly, input logic [7:0] rd,
                         input bit drop_mid);
        exp_t e;
        int   n;
        n = 0;
        while (wb_cyc_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cyc"}, wb_cyc_o, 1);
        if (wb_cyc_o !== 1'b1) return;
        check({tag, "_sb"}, (sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_stb"}, wb_stb_o, 1);
        check({tag, "_adr"}, wb_adr_o, e.adr);
        check({tag, "_we"}, wb_we_o, e.we);
        check({tag, "_dat"}, wb_dat_o, e.dat);
        if (drop_mid) req_valid_i = '0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check({tag, "_hold_cyc"}, wb_cyc_o, 1);
            check({tag, "_hold_adr"}, {wb_we_o, wb_adr_o, wb_dat_o}, {e.we, e.adr, e.dat});
            check({tag, "_hold_rdy"}, req_ready_o, 0);
        end
        wb_dat_i = rd;
        wb_ack_i = 1'b1;
        #1;
        check({tag, "_ready"}, req_ready_o, e.rdy);
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        check({tag, "_release"}, {wb_cyc_o, wb_stb_o}, 0);
        check({tag, "_rdy_after"}, req_ready_o, 0);
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_cyc"}, {wb_cyc_o, busy_o}, 0);
            check({tag, "_rdy"}, req_ready_o, 0);
        end
    endtask

`ifdef UART_SCHED_INIT_EN
    task automatic run_init(input string tag);
        push(3'd3, 1'b1, 8'h83, 4'h0);
        push(3'd0, 1'b1, 8'h1B, 4'h0);
        push(3'd1, 1'b1, 8'h00, 4'h0);
        push(3'd3, 1'b1, 8'h03, 4'h0);
        push(3'd2, 1'b1, 8'h07, 4'h0);
        for (int k = 0; k < 5; k++) begin
            check({tag, "_done_before"}, init_done_o, 0);
            serve({tag, "_wr"}, 2, 8'h00, 1'b0);
            check({tag, "_done_after"}, init_done_o, (k == 4) ? 1 : 0);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        wb_dat_i    = 8'h00;
        wb_ack_i    = 1'b0;
        for (int i = 0; i < NREQ; i++) seq_cnt[i] = 0;
        repeat (2) @(negedge clk);
        check("reset_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
        check("reset_ready", req_ready_o, 0);
        check("reset_busy", busy_o, 0);
`ifdef UART_SCHED_INIT_EN
        check("reset_init_done", init_done_o, 0);
`else
        check("reset_init_done", init_done_o, 1);
`endif

        // All four requesters valid continuously.
        for (int i = 0; i < NREQ; i++) set_byte(i, req_byte(i));
        req_valid_i = 4'hF;
        rst_i = 1'b0;
`ifdef UART_SCHED_INIT_EN
        run_init("init");
`endif
        push(3'd5, 1'b0, 8'h00, 4'h0);
        serve("first_lsr", 1, 8'h20, 1'b0);
        check("init_done_run", init_done_o, 1);
        for (int w = 0; w < 16; w++) begin
            g = w % NREQ;
            push(3'd0, 1'b1, req_byte(g), 4'(1 << g));
            serve("burst_thr", w % 3, 8'h00, 1'b0);
            seq_cnt[g]++;
            set_byte(g, req_byte(g));
        end
        // Burst exhausted: LSR polled again, THRE clear three times.
        for (int p = 0; p < 4; p++) begin
            push(3'd5, 1'b0, 8'h00, 4'h0);
            serve("poll", 0, (p < 3) ? 8'h00 : 8'h60, 1'b0);
        end
        push(3'd0, 1'b1, req_byte(0), 4'b0001);
        serve("thr17_drop", 2, 8'h00, 1'b1);
        quiet("idle_after_drop", 6);

        // Single requester 2.
        set_byte(2, 8'hA5);
        req_valid_i = 4'b0100;
        push(3'd5, 1'b0, 8'h00, 4'h0);
        serve("single_lsr", 1, 8'h20, 1'b0);
        push(3'd0, 1'b1, 8'hA5, 4'b0100);
        serve("single_thr", 1, 8'h00, 1'b0);
        req_valid_i = '0;
        quiet("single_idle", 5);

        // Reset while a THR write waits for ack, with ack arriving in the reset cycle.
        set_byte(1, 8'h3C);
        req_valid_i = 4'b0010;
        push(3'd5, 1'b0, 8'h00, 4'h0);
        serve("rst_lsr", 0, 8'h20, 1'b0);
        g = 0;
        while (wb_cyc_o !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("rst_thr_cyc", wb_cyc_o, 1);
        check("rst_thr_dat", {wb_adr_o, wb_dat_o}, {3'd0, 8'h3C});
        rst_i    = 1'b1;
        wb_ack_i = 1'b1;
        #1;
        check("rst_cycle_ready", req_ready_o, 0);
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("rst_after_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
        check("rst_after_ready", req_ready_o, 0);
`ifdef UART_SCHED_INIT_EN
        check("rst_after_init_done", init_done_o, 0);
`else
        check("rst_after_init_done", init_done_o, 1);
`endif
        rst_i = 1'b0;

        // After reset rr_ptr is 0: requesters 1 and 3 are served in that order.
        set_byte(3, 8'hC3);
        req_valid_i = 4'b1010;
`ifdef UART_SCHED_INIT_EN
        run_init("reinit");
`endif
        push(3'd5, 1'b0, 8'h00, 4'h0);
        serve("post_rst_lsr", 1, 8'h20, 1'b0);
        push(3'd0, 1'b1, 8'h3C, 4'b0010);
        serve("post_rst_thr1", 0, 8'h00, 1'b0);
        req_valid_i = 4'b1000;
        push(3'd0, 1'b1, 8'hC3, 4'b1000);
        serve("post_rst_thr3", 3, 8'h00, 1'b0);
        req_valid_i = '0;
        quiet("final_idle", 4);
        check("sb_drained", sb.size(), 0);
        check("final_init_done", init_done_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters (2..8).
REQ-002 Parameter DIVISOR, default 16'd27: baud divisor written to DLL/DLM.
REQ-003 Parameter LCR_VAL, default 8'h03: line control value (8N1); bit 7 is ignored.
REQ-004 Parameter BURST, default 16: THR writes allowed per observed THRE (the UART FIFO depth).
REQ-005 Clocking and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-006 Ports, in order: clk_i in 1, clock.
REQ-007 rst_i in 1, synchronous active-high reset.
REQ-008 req_valid_i in NREQ, byte pending per requester.
REQ-009 req_data_i in NREQ*8, byte per requester; requester i occupies bits [8i+7:8i].
REQ-010 req_ready_o out NREQ, one-cycle accept pulse.
REQ-011 wb_cyc_o out 1 and wb_stb_o out 1, Wishbone master cycle and strobe.
REQ-012 wb_we_o out 1, write enable.
REQ-013 wb_adr_o out 3, UART register address.
REQ-014 wb_dat_o out 8, write data.
REQ-015 wb_dat_i in 8, read data.
REQ-016 wb_ack_i in 1, Wishbone acknowledge.
REQ-017 init_done_o out 1, UART configured.
REQ-018 busy_o out 1, a Wishbone cycle is in progress.

Function
REQ-019 Every Wishbone access is a single classic cycle: cyc, stb, adr, we and dat are held stable from assertion until the cycle of wb_ack_i, and are deasserted in the cycle after ack; there is no wait-state limit.
REQ-020 FSM states: INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, IDLE, POLL_LSR, WRITE_THR.
REQ-021 Init sequence, one write per state, advancing on ack:
  - LCR(3) <= LCR_VAL|8'h80
  - DLL(0) <= DIVISOR[7:0]
  - DLM(1) <= DIVISOR[15:8]
  - LCR(3) <= LCR_VAL&8'h7F
  - FCR(2) <= 8'h07
REQ-022 init_done_o rises in the cycle after the FCR ack and stays high until reset.
REQ-023 IDLE: when any req_valid_i bit is high, go to POLL_LSR.
REQ-024 POLL_LSR: read LSR (adr 5). On ack:
  - wb_dat_i[5]=1: load the burst counter with BURST and go to WRITE_THR.
  - wb_dat_i[5]=0: issue a new poll.
REQ-025 WRITE_THR: grant the lowest-index valid requester at or after rr_ptr, cyclically; the grant and data are latched at cycle start; write THR (adr 0).
REQ-026 On THR ack:
  - req_ready_o[grant] pulses for exactly that cycle;
  - rr_ptr <= grant+1, modulo NREQ;
  - burst counter decrements.
REQ-027 After a THR ack:
  - counter is 0: go to POLL_LSR if any request is valid, otherwise IDLE;
  - counter is nonzero and no request is valid: go to IDLE, discarding the remaining burst.
REQ-028 A requester dropping req_valid_i mid-cycle does not abort the write; its latched byte is sent and ready still pulses.
REQ-029 Arbitration is fair: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
REQ-030 At most one req_ready_o bit is high in any cycle.
REQ-031 busy_o = wb_cyc_o.

Reset
REQ-032 rst_i sampled high in any state, including mid-Wishbone-cycle: the next cycle has cyc/stb/we=0, adr=0, dat=0, req_ready_o=0, init_done_o=0, rr_ptr=0, counter=0.
REQ-033 State after reset is INIT_LCR_DLAB (or IDLE per REQ-035).
REQ-034 An ack arriving in the reset cycle is ignored.

Configuration
REQ-035 Macro UART_SCHED_INIT_EN:
  - defined: the INIT_* states exist and the REQ-021 sequence runs after reset;
  - undefined: INIT_* states are not compiled, reset enters IDLE, init_done_o is tied 1, and DIVISOR and LCR_VAL are unused.

Structure
REQ-036 uart_package holds the UART register address constants (RBR_THR=0, IER=1, FCR=2, LCR=3, LSR=5, DLL=0, DLM=1), LSR_THRE_BIT=5, and the scheduler state enum type.
REQ-037 One sub-module, uart_rr_arbiter, computes the combinational round-robin grant from valid bits and rr_ptr.

Verification
REQ-038 Init, with ack delayed 2 cycles: observed writes are (3,83),(0,1B),(1,00),(3,03),(2,07), each held until ack; init_done_o rises 1 cycle after the fifth ack.
REQ-039 Single requester 2 valid with 8'hA5, LSR returns 8'h20: one LSR read, then THR write of A5; req_ready_o=4'b0100 for 1 cycle; return to IDLE.
REQ-040 All 4 valid continuously with distinct bytes, THRE always set: 16 THR writes in grant order 0,1,2,3 repeated 4 times, then an LSR poll before the 17th write.
REQ-041 LSR returns 8'h00 three times, then 8'h60: exactly 4 LSR reads precede the first THR write.
REQ-042 Reset asserted while a THR write waits for ack: cyc/stb are 0 in the next cycle, no req_ready_o pulse occurs, and the init sequence restarts.
REQ-043 Built without UART_SCHED_INIT_EN: the first bus access after reset is an LSR read, and init_done_o is 1 throughout.
